// File: rtl/if_id_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_fetch_stage_pkg
//  Description : Shared widths and encodings for the fetch / IF-ID stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_id_fetch_stage_pkg;

    // Architectural address width and instruction width.
    localparam int c_XLEN = 64;
    localparam int c_ILEN = 32;

    // Bubble instruction: addi x0,x0,0.
    localparam logic [c_ILEN-1:0] c_NOP_INSTR = 32'h00000013;

    // Byte distance between consecutive instructions.
    localparam logic [c_XLEN-1:0] c_INSTR_STRIDE = 64'd4;

endpackage : if_id_fetch_stage_pkg
`default_nettype wire

// File: rtl/if_id_fetch_stage_instr_memory.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_fetch_stage_instr_memory
//  Description : Read-only byte-addressed instruction memory. Contents come
//                from the IMEM_INIT parameter (byte i = IMEM_INIT[8i+7:8i]),
//                read is combinational and little-endian, and an alignment /
//                range check flags bad fetch addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_stage_instr_memory
    import if_id_fetch_stage_pkg::*;
#(
    parameter int                      IMEM_BYTES = 64,
    parameter logic [8*IMEM_BYTES-1:0] IMEM_INIT  = '0
) (
    input  logic [c_XLEN-1:0] pc_i,
    output logic [c_ILEN-1:0] instr_o,
    output logic              bad_fetch_o
);

    localparam int NWORDS = IMEM_BYTES / 4;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    // Highest address at which a full 32-bit word still fits.
    localparam logic [c_XLEN-1:0] c_LAST_ADDR = 64'(IMEM_BYTES - 4);

    logic [7:0]        w_mem   [IMEM_BYTES];
    logic [c_ILEN-1:0] w_words [NWORDS];
    logic [WIDX_W-1:0] w_widx;
    logic              w_in_range;

    for (genvar gi = 0; gi < IMEM_BYTES; gi++) begin : g_bytes
        assign w_mem[gi] = IMEM_INIT[8*gi +: 8];
    end

    // Little-endian word assembly: lowest address is the least significant byte.
    for (genvar gw = 0; gw < NWORDS; gw++) begin : g_words
        assign w_words[gw] = {w_mem[4*gw+3], w_mem[4*gw+2], w_mem[4*gw+1], w_mem[4*gw]};
    end

    // Full-width compare so high PC bits can never alias into the array.
    assign w_in_range  = (pc_i <= c_LAST_ADDR);
    assign w_widx      = pc_i[WIDX_W+1:2];
    assign instr_o     = w_in_range ? w_words[w_widx] : '0;
    assign bad_fetch_o = (pc_i[1:0] != 2'b00) || !w_in_range;

endmodule : if_id_fetch_stage_instr_memory
`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_fetch_stage
//  Description : Instruction fetch plus IF/ID pipeline register. Supports a
//                load-use stall (hold), a branch flush (bubble) that wins over
//                stall, and a sticky fault flag for bad fetch addresses.
//                IMEM_BYTES must be a multiple of 4 and at least 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter int                      IMEM_BYTES = 64,
    parameter logic [c_ILEN-1:0]       NOP_INSTR  = c_NOP_INSTR,
    parameter logic [8*IMEM_BYTES-1:0] IMEM_INIT  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [c_XLEN-1:0] PC_Out,
    input  logic              IF_ID_Write,
    input  logic              IF_ID_Flush,
    output logic [c_XLEN-1:0] IF_ID_PC,
    output logic [c_XLEN-1:0] IF_ID_PC_Plus4,
    output logic [c_ILEN-1:0] IF_ID_Instr,
    output logic              IF_ID_Valid,
    output logic              Fetch_Fault
);

    logic [c_ILEN-1:0] w_fetch_instr;
    logic              w_bad_fetch;
    logic [c_XLEN-1:0] w_pc_plus4;

    logic [c_XLEN-1:0] pc_q,    pc_d;
    logic [c_XLEN-1:0] pc4_q,   pc4_d;
    logic [c_ILEN-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    if_id_fetch_stage_instr_memory #(
        .IMEM_BYTES (IMEM_BYTES),
        .IMEM_INIT  (IMEM_INIT)
    ) u_imem (
        .pc_i        (PC_Out),
        .instr_o     (w_fetch_instr),
        .bad_fetch_o (w_bad_fetch)
    );

    // Wraps modulo 2^64 by construction.
    assign w_pc_plus4 = PC_Out + c_INSTR_STRIDE;

    // Next-state selection: flush > stall > bad fetch > normal fetch.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (IF_ID_Flush) begin
            pc_d    = PC_Out;
            pc4_d   = w_pc_plus4;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (IF_ID_Write) begin
            pc_d  = PC_Out;
            pc4_d = w_pc_plus4;
            if (w_bad_fetch) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                instr_d = w_fetch_instr;
                valid_d = 1'b1;
            end
        end
    end

    // IF/ID register and sticky fault flag, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign IF_ID_PC       = pc_q;
    assign IF_ID_PC_Plus4 = pc4_q;
    assign IF_ID_Instr    = instr_q;
    assign IF_ID_Valid    = valid_q;
    assign Fetch_Fault    = fault_q;

endmodule : if_id_fetch_stage
`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_fetch_stage
//  Description : Self-checking bench for if_id_fetch_stage with a behavioural
//                reference model of the IF/ID register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_stage;

    localparam int TB_BYTES = 64;

    // Program bytes 0..7 are the two-instruction sequence; the rest is filler.
    function automatic logic [8*TB_BYTES-1:0] build_init();
        logic [8*TB_BYTES-1:0] v;
        logic [63:0]           prog;
        prog = 64'h00a00593_00500513;
        v    = '0;
        for (int i = 0; i < TB_BYTES; i++)
            v[8*i +: 8] = (i < 8) ? prog[8*i +: 8] : 8'((i * 37 + 11) & 255);
        return v;
    endfunction

    localparam logic [8*TB_BYTES-1:0] TB_INIT = build_init();
    localparam logic [31:0]           NOP     = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] PC_Out = '0;
    logic        IF_ID_Write = 1'b1;
    logic        IF_ID_Flush = 1'b0;
    logic [63:0] IF_ID_PC;
    logic [63:0] IF_ID_PC_Plus4;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        Fetch_Fault;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0]  tb_mem [TB_BYTES];
    logic [63:0] m_pc, m_pc4;
    logic [31:0] m_instr;
    logic        m_valid, m_fault;

    if_id_fetch_stage #(
        .IMEM_BYTES (TB_BYTES),
        .NOP_INSTR  (NOP),
        .IMEM_INIT  (TB_INIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_Out         (PC_Out),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_PC_Plus4 (IF_ID_PC_Plus4),
        .IF_ID_Instr    (IF_ID_Instr),
        .IF_ID_Valid    (IF_ID_Valid),
        .Fetch_Fault    (Fetch_Fault)
    );

    always #5 clk = ~clk;

    function automatic logic [161:0] obs();
        return {IF_ID_PC, IF_ID_PC_Plus4, IF_ID_Instr, IF_ID_Valid, Fetch_Fault};
    endfunction

    function automatic logic [161:0] expv();
        return {m_pc, m_pc4, m_instr, m_valid, m_fault};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_pc4 = '0; m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    // One clock edge of the pipeline register, from the priority rules.
    task automatic model_edge(input logic [63:0] pc, input logic wr, input logic fl);
        logic fetch_ok;
        int   a;
        fetch_ok = (pc % 4 == 0) && (pc <= 64'(TB_BYTES - 4));
        if (fl) begin
            m_pc = pc; m_pc4 = pc + 64'd4; m_instr = NOP; m_valid = 1'b0;
        end else if (wr) begin
            m_pc = pc; m_pc4 = pc + 64'd4;
            if (fetch_ok) begin
                a       = int'(pc);
                m_instr = {tb_mem[a+3], tb_mem[a+2], tb_mem[a+1], tb_mem[a]};
                m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0; m_fault = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, sample 1 ns later.
    task automatic step(input logic [63:0] pc, input logic wr, input logic fl);
        PC_Out = pc; IF_ID_Write = wr; IF_ID_Flush = fl;
        @(posedge clk);
        model_edge(pc, wr, fl);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        PC_Out = 64'h8;
        reset  = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", obs(), expv());
        end
        total++;
        if (IF_ID_Instr !== 32'h00000013 || IF_ID_Valid !== 1'b0 || IF_ID_PC !== 64'h0 || Fetch_Fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_const got instr=%h v=%b pc=%h f=%b exp instr=00000013 v=0 pc=0 f=0",
                     IF_ID_Instr, IF_ID_Valid, IF_ID_PC, Fetch_Fault);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        step(64'h0, 1'b1, 1'b0);
        total++;
        if (IF_ID_Instr !== 32'h00500513 || IF_ID_PC !== 64'h0 || IF_ID_PC_Plus4 !== 64'h4 || IF_ID_Valid !== 1'b1) begin
            bad++;
            $display("FAIL seq_edge1 got instr=%h pc=%h pc4=%h v=%b exp instr=00500513 pc=0 pc4=4 v=1",
                     IF_ID_Instr, IF_ID_PC, IF_ID_PC_Plus4, IF_ID_Valid);
        end
        step(64'h4, 1'b1, 1'b0);
        total++;
        if (IF_ID_Instr !== 32'h00a00593 || IF_ID_PC !== 64'h4 || obs() !== expv()) begin
            bad++;
            $display("FAIL seq_edge2 got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_stall();
        logic [63:0] pcs [3];
        pcs[0] = 64'h4; pcs[1] = 64'h8; pcs[2] = 64'hC;
        for (int i = 0; i < 3; i++) begin
            step(pcs[i], 1'b0, 1'b0);
            total++;
            if (IF_ID_PC !== 64'h4 || IF_ID_Instr !== 32'h00a00593 || obs() !== expv()) begin
                bad++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs(), expv());
            end
        end
        step(64'h8, 1'b1, 1'b0);
        total++;
        if (obs() !== expv() || IF_ID_PC !== 64'h8 || IF_ID_Valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_flush();
        step(64'h8, 1'b0, 1'b1);
        total++;
        if (IF_ID_Instr !== 32'h00000013 || IF_ID_Valid !== 1'b0 || IF_ID_PC !== 64'h8 || IF_ID_PC_Plus4 !== 64'hC) begin
            bad++;
            $display("FAIL flush_over_stall got instr=%h v=%b pc=%h pc4=%h exp instr=00000013 v=0 pc=8 pc4=c",
                     IF_ID_Instr, IF_ID_Valid, IF_ID_PC, IF_ID_PC_Plus4);
        end
    endtask

    task automatic test_faults();
        // Bad PC held under stall must not fault.
        step(64'h2, 1'b0, 1'b0);
        total++;
        if (Fetch_Fault !== 1'b0 || obs() !== expv()) begin
            bad++;
            $display("FAIL stall_bad_pc got=%h exp=%h", obs(), expv());
        end
        step(64'h2, 1'b1, 1'b0);
        total++;
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== NOP || Fetch_Fault !== 1'b1 || obs() !== expv()) begin
            bad++;
            $display("FAIL misaligned got=%h exp=%h", obs(), expv());
        end
        step(64'h0, 1'b1, 1'b0);
        total++;
        if (IF_ID_Valid !== 1'b1 || Fetch_Fault !== 1'b1 || obs() !== expv()) begin
            bad++;
            $display("FAIL fault_sticky got=%h exp=%h", obs(), expv());
        end
        pulse_reset();
        step(64'h3C, 1'b1, 1'b0);
        total++;
        if (IF_ID_Valid !== 1'b1 || Fetch_Fault !== 1'b0 || obs() !== expv()) begin
            bad++;
            $display("FAIL last_word got=%h exp=%h", obs(), expv());
        end
        step(64'h40, 1'b1, 1'b0);
        total++;
        if (IF_ID_Valid !== 1'b0 || Fetch_Fault !== 1'b1 || obs() !== expv()) begin
            bad++;
            $display("FAIL past_end got=%h exp=%h", obs(), expv());
        end
        // High bits set but low bits in range: must not alias.
        pulse_reset();
        step(64'h1_0000_0000, 1'b1, 1'b0);
        total++;
        if (Fetch_Fault !== 1'b1 || obs() !== expv()) begin
            bad++;
            $display("FAIL high_alias got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_wrap_reset();
        step(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
        total++;
        if (IF_ID_PC_Plus4 !== 64'h0 || Fetch_Fault !== 1'b1 || obs() !== expv()) begin
            bad++;
            $display("FAIL wrap got=%h exp=%h", obs(), expv());
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (Fetch_Fault !== 1'b0 || obs() !== expv()) begin
            bad++;
            $display("FAIL async_pulse got=%h exp=%h", obs(), expv());
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [63:0] pc;
        logic        wr, fl;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0, 1: pc = 64'(4 * $urandom_range(0, TB_BYTES / 4 - 1));
                2:    pc = 64'($urandom_range(0, TB_BYTES + 8));
                default: pc = {$urandom, $urandom};
            endcase
            wr = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 5) == 0);
            step(pc, wr, fl);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random[%0d] pc=%h wr=%b fl=%b got=%h exp=%h", n, pc, wr, fl, obs(), expv());
            end
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset();
                total++;
                if (obs() !== expv()) begin
                    bad++;
                    $display("FAIL random_reset[%0d] got=%h exp=%h", n, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < TB_BYTES; i++) tb_mem[i] = TB_INIT[8*i +: 8];
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_faults();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_id_fetch_stage
`default_nettype wire
